// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP
   } state_t;

   // funct3 size/sign encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // True when the op is a legal funct3 for its direction and naturally aligned.
   function automatic logic op_ok(input logic we, input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_B:    return 1'b1;
         F3_H:    return !a[0];
         F3_W:    return a == 2'b00;
         F3_BU:   return !we;
         F3_HU:   return !we && !a[0];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-wide memory bus between the load/store unit and memory.
interface lsu_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a bus word and sign- or zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] bus_rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted;

   // Shift the addressed lane down to bit 0, then extend per funct3.
   always_comb begin
      shifted = bus_rdata >> {addr_lo, 3'b000};
      case (funct3)
         F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   data = {24'h0, shifted[7:0]};
         F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   data = {16'h0, shifted[15:0]};
         default: data = bus_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding bus transaction, lane placement for stores,
// lane select/extension for loads, wait-cycle timeout.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lsu_valid,
   input  logic        lsu_we,
   input  logic [2:0]  lsu_funct3,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic        lsu_busy,
   output logic        lsu_done,
   output logic        lsu_err,
   output logic [31:0] rdata,
   lsu_if.master       bus
);

   // Counter only needs to reach TIMEOUT-1; the TIMEOUT-th wait cycle ends REQ.
   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [1:0]    addr_lo_q;
   logic [31:0]   st_wdata;
   logic [3:0]    st_wstrb;
   logic [31:0]   load_data;

   assign lsu_busy = (state != ST_IDLE);

   // Place store data on byte lanes and derive byte enables from the request.
   always_comb begin
      st_wdata = '0;
      st_wstrb = '0;
      if (lsu_we) begin
         case (lsu_funct3[1:0])
            2'b00: begin
               st_wstrb = 4'b0001 << lsu_addr[1:0];
               st_wdata = {4{lsu_wdata[7:0]}};
            end
            2'b01: begin
               st_wstrb = 4'b0011 << lsu_addr[1:0];
               st_wdata = {2{lsu_wdata[15:0]}};
            end
            default: begin
               st_wstrb = 4'b1111;
               st_wdata = lsu_wdata;
            end
         endcase
      end
   end

   lsu_load_align u_align (
      .bus_rdata (bus.bus_rdata),
      .addr_lo   (addr_lo_q),
      .funct3    (f3_q),
      .data      (load_data)
   );

   // Transaction FSM with registered bus and completion outputs.
   // lsu_err doubles as the error flag: it is only ever set on entry to RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         wait_cnt      <= '0;
         we_q          <= 1'b0;
         f3_q          <= '0;
         addr_lo_q     <= '0;
         rdata         <= '0;
         lsu_done      <= 1'b0;
         lsu_err       <= 1'b0;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= '0;
         bus.bus_wdata <= '0;
         bus.bus_wstrb <= '0;
      end else begin
         lsu_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               lsu_err <= 1'b0;
               if (lsu_valid) begin
                  if (op_ok(lsu_we, lsu_funct3, lsu_addr[1:0])) begin
                     state         <= ST_REQ;
                     wait_cnt      <= '0;
                     we_q          <= lsu_we;
                     f3_q          <= lsu_funct3;
                     addr_lo_q     <= lsu_addr[1:0];
                     bus.bus_req   <= 1'b1;
                     bus.bus_we    <= lsu_we;
                     bus.bus_addr  <= {lsu_addr[31:2], 2'b00};
                     bus.bus_wdata <= st_wdata;
                     bus.bus_wstrb <= st_wstrb;
                  end else begin
                     state    <= ST_RESP;
                     lsu_done <= 1'b1;
                     lsu_err  <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (bus.bus_ack) begin
                  bus.bus_req <= 1'b0;
                  if (!we_q) rdata <= load_data;
                  state    <= ST_RESP;
                  lsu_done <= 1'b1;
                  lsu_err  <= 1'b0;
               end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  bus.bus_req <= 1'b0;
                  state       <= ST_RESP;
                  lsu_done    <= 1'b1;
                  lsu_err     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               state   <= ST_IDLE;
               lsu_err <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a hand-driven memory bus.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lsu_valid;
   logic        lsu_we;
   logic [2:0]  lsu_funct3;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic        lsu_busy;
   logic        lsu_done;
   logic        lsu_err;
   logic [31:0] rdata;

   int n_checks = 0;
   int n_fail   = 0;

   lsu_if bus_if ();

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lsu_valid  (lsu_valid),
      .lsu_we     (lsu_we),
      .lsu_funct3 (lsu_funct3),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .lsu_busy   (lsu_busy),
      .lsu_done   (lsu_done),
      .lsu_err    (lsu_err),
      .rdata      (rdata),
      .bus        (bus_if)
   );

   always #5 clk = ~clk;

   // Present one request across a single rising edge; returns at the following negedge.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
      @(negedge clk);
      lsu_valid  = 1'b1;
      lsu_we     = we;
      lsu_funct3 = f3;
      lsu_addr   = addr;
      lsu_wdata  = wd;
      @(negedge clk);
      lsu_valid  = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = '0; lsu_addr = '0; lsu_wdata = '0;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus_if.bus_req, bus_if.bus_we, lsu_done, lsu_err, lsu_busy} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 00000",
                            {bus_if.bus_req, bus_if.bus_we, lsu_done, lsu_err, lsu_busy});
      end
      n_checks++;
      if ({rdata, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb} !== 100'h0) begin
         n_fail++; $display("FAIL reset_data: rdata %h addr %h wdata %h wstrb %b, want all 0",
                            rdata, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_lb_sign;
      issue(1'b0, F3_B, 32'h103, 32'h0);
      n_checks++;
      if (!(bus_if.bus_req === 1'b1 && bus_if.bus_addr === 32'h100 && bus_if.bus_wstrb === 4'b0000
            && bus_if.bus_we === 1'b0 && lsu_busy === 1'b1)) begin
         n_fail++; $display("FAIL lb_req: req %b addr %h wstrb %b we %b busy %b, want 1 100 0000 0 1",
                            bus_if.bus_req, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_we, lsu_busy);
      end
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h80AABBCC;
      @(negedge clk);
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'hDEADDEAD;
      n_checks++;
      if (!(lsu_done === 1'b1 && lsu_err === 1'b0 && rdata === 32'hFFFFFF80 && bus_if.bus_req === 1'b0)) begin
         n_fail++; $display("FAIL lb_done: done %b err %b rdata %h req %b, want 1 0 ffffff80 0",
                            lsu_done, lsu_err, rdata, bus_if.bus_req);
      end
      @(negedge clk);
      n_checks++;
      if (!(lsu_done === 1'b0 && lsu_busy === 1'b0 && rdata === 32'hFFFFFF80)) begin
         n_fail++; $display("FAIL lb_pulse: done %b busy %b rdata %h, want 0 0 ffffff80",
                            lsu_done, lsu_busy, rdata);
      end
   endtask

   task automatic test_sh_store;
      issue(1'b1, F3_H, 32'h202, 32'h0000BEEF);
      @(negedge clk);
      n_checks++;
      if (!(bus_if.bus_req === 1'b1 && bus_if.bus_we === 1'b1 && bus_if.bus_addr === 32'h200
            && bus_if.bus_wstrb === 4'b1100 && bus_if.bus_wdata === 32'hBEEFBEEF)) begin
         n_fail++; $display("FAIL sh_lanes: req %b we %b addr %h wstrb %b wdata %h, want 1 1 200 1100 beefbeef",
                            bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wstrb, bus_if.bus_wdata);
      end
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h12345678;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      n_checks++;
      if (!(lsu_done === 1'b1 && lsu_err === 1'b0 && rdata === 32'hFFFFFF80)) begin
         n_fail++; $display("FAIL sh_done: done %b err %b rdata %h, want 1 0 ffffff80",
                            lsu_done, lsu_err, rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_sb_word_store;
      issue(1'b1, F3_B, 32'h401, 32'hAABBCC5A);
      n_checks++;
      if (!(bus_if.bus_wstrb === 4'b0010 && bus_if.bus_wdata === 32'h5A5A5A5A && bus_if.bus_addr === 32'h400)) begin
         n_fail++; $display("FAIL sb_lanes: wstrb %b wdata %h addr %h, want 0010 5a5a5a5a 400",
                            bus_if.bus_wstrb, bus_if.bus_wdata, bus_if.bus_addr);
      end
      bus_if.bus_ack = 1'b1;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      @(negedge clk);
      issue(1'b1, F3_W, 32'h500, 32'h01234567);
      n_checks++;
      if (!(bus_if.bus_wstrb === 4'b1111 && bus_if.bus_wdata === 32'h01234567)) begin
         n_fail++; $display("FAIL sw_lanes: wstrb %b wdata %h, want 1111 01234567",
                            bus_if.bus_wstrb, bus_if.bus_wdata);
      end
      bus_if.bus_ack = 1'b1;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_misaligned;
      issue(1'b0, F3_W, 32'h101, 32'h0);
      n_checks++;
      if (!(bus_if.bus_req === 1'b0 && lsu_done === 1'b1 && lsu_err === 1'b1 && rdata === 32'hFFFFFF80)) begin
         n_fail++; $display("FAIL lw_misaligned: req %b done %b err %b rdata %h, want 0 1 1 ffffff80",
                            bus_if.bus_req, lsu_done, lsu_err, rdata);
      end
      @(negedge clk);
      n_checks++;
      if (!(lsu_done === 1'b0 && lsu_err === 1'b0 && lsu_busy === 1'b0)) begin
         n_fail++; $display("FAIL err_pulse: done %b err %b busy %b, want 0 0 0", lsu_done, lsu_err, lsu_busy);
      end
   endtask

   task automatic test_illegal_f3;
      issue(1'b1, F3_BU, 32'h20, 32'h0);
      n_checks++;
      if (!(bus_if.bus_req === 1'b0 && lsu_done === 1'b1 && lsu_err === 1'b1)) begin
         n_fail++; $display("FAIL store_unsigned: req %b done %b err %b, want 0 1 1",
                            bus_if.bus_req, lsu_done, lsu_err);
      end
      @(negedge clk);
      issue(1'b0, 3'b011, 32'h20, 32'h0);
      n_checks++;
      if (!(bus_if.bus_req === 1'b0 && lsu_done === 1'b1 && lsu_err === 1'b1)) begin
         n_fail++; $display("FAIL f3_011: req %b done %b err %b, want 0 1 1",
                            bus_if.bus_req, lsu_done, lsu_err);
      end
      @(negedge clk);
   endtask

   task automatic test_load_ext;
      issue(1'b0, F3_BU, 32'h1, 32'h0);
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1234F678;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      n_checks++;
      if (rdata !== 32'h000000F6) begin
         n_fail++; $display("FAIL lbu_ext: rdata %h want 000000f6", rdata);
      end
      @(negedge clk);
      issue(1'b0, F3_H, 32'h12, 32'h0);
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFEDC1234;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      n_checks++;
      if (rdata !== 32'hFFFFFEDC) begin
         n_fail++; $display("FAIL lh_ext: rdata %h want fffffedc", rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout;
      issue(1'b0, F3_HU, 32'h10, 32'h0);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (!(bus_if.bus_req === 1'b1 && lsu_done === 1'b0)) begin
            n_fail++; $display("FAIL timeout_wait%0d: req %b done %b, want 1 0", i, bus_if.bus_req, lsu_done);
         end
         @(negedge clk);
      end
      n_checks++;
      if (!(bus_if.bus_req === 1'b0 && lsu_done === 1'b1 && lsu_err === 1'b1 && rdata === 32'hFFFFFEDC)) begin
         n_fail++; $display("FAIL timeout_done: req %b done %b err %b rdata %h, want 0 1 1 fffffedc",
                            bus_if.bus_req, lsu_done, lsu_err, rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_ack_at_timeout;
      issue(1'b0, F3_HU, 32'h12, 32'h0);
      repeat (3) @(negedge clk);
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h8001ABCD;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      n_checks++;
      if (!(lsu_done === 1'b1 && lsu_err === 1'b0 && rdata === 32'h00008001)) begin
         n_fail++; $display("FAIL ack_wins: done %b err %b rdata %h, want 1 0 00008001",
                            lsu_done, lsu_err, rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_stray_ack;
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h55555555;
      repeat (2) @(negedge clk);
      bus_if.bus_ack = 1'b0;
      n_checks++;
      if (!(lsu_done === 1'b0 && lsu_busy === 1'b0 && rdata === 32'h00008001)) begin
         n_fail++; $display("FAIL stray_ack: done %b busy %b rdata %h, want 0 0 00008001",
                            lsu_done, lsu_busy, rdata);
      end
   endtask

   task automatic test_reset_mid;
      issue(1'b0, F3_W, 32'h300, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (!(bus_if.bus_req === 1'b0 && lsu_busy === 1'b0 && rdata === 32'h0 && bus_if.bus_addr === 32'h0)) begin
         n_fail++; $display("FAIL async_reset: req %b busy %b rdata %h addr %h, want 0 0 0 0",
                            bus_if.bus_req, lsu_busy, rdata, bus_if.bus_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(1'b0, F3_W, 32'h300, 32'h0);
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hCAFEF00D;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      n_checks++;
      if (!(lsu_done === 1'b1 && lsu_err === 1'b0 && rdata === 32'hCAFEF00D)) begin
         n_fail++; $display("FAIL lw_after_reset: done %b err %b rdata %h, want 1 0 cafef00d",
                            lsu_done, lsu_err, rdata);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_lb_sign();
      test_sh_store();
      test_sb_word_store();
      test_misaligned();
      test_illegal_f3();
      test_load_ext();
      test_timeout();
      test_ack_at_timeout();
      test_stray_ack();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the maximum number of bus wait cycles before a transaction is abandoned.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 lsu_valid  input  1  SHALL mark a memory operation request from the pipeline.
REQ-005 lsu_we  input  1  SHALL select store (1) or load (0).
REQ-006 lsu_funct3  input  3  SHALL give size and sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-007 lsu_addr  input  32  SHALL be the byte address (ALU result).
REQ-008 lsu_wdata  input  32  SHALL be the store data (rs2), right-aligned.
REQ-009 lsu_busy  output  1  SHALL be high whenever state is not IDLE.
REQ-010 lsu_done  output  1  SHALL be a one-cycle completion pulse.
REQ-011 lsu_err  output  1  SHALL qualify lsu_done as an error completion (misaligned, illegal funct3, timeout).
REQ-012 rdata  output  32  SHALL be the aligned, extended load data that feeds the writeback mux.
REQ-013 bus_req, bus_we  output  1 each  SHALL form the memory request and direction.
REQ-014 bus_addr  output  32  SHALL be word-aligned (bits [1:0] = 00).
REQ-015 bus_wdata  output  32 / bus_wstrb  output  4  SHALL carry lane-placed store data and byte enables.
REQ-016 bus_ack  input  1 / bus_rdata  input  32  SHALL carry the memory response; bus_rdata is valid only in the bus_ack cycle.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and RESP.
REQ-018 IDLE transitions: lsu_valid with a legal, aligned op -> latch all inputs, go to REQ; lsu_valid with an illegal/misaligned op -> set the error flag, go to RESP.
REQ-019 Misalignment SHALL be defined as half with addr[0]=1, or word with addr[1:0]!=00; funct3 011, 110 and 111 SHALL be illegal, and 100/101 SHALL be illegal for stores.
REQ-020 In REQ, bus_req SHALL be 1 with bus_addr/we/wdata/wstrb held stable until bus_ack.
REQ-021 Store lanes: byte wstrb = 0001<<addr[1:0], data byte replicated ×4; half wstrb = 0011<<addr[1:0], data half replicated ×2; word wstrb = 1111; loads wstrb = 0000.
REQ-022 On bus_ack in REQ, a load SHALL capture bus_rdata, select the lane by the latched addr[1:0], sign- or zero-extend it into rdata, and go to RESP.
REQ-023 A wait counter SHALL clear on REQ entry and increment each REQ cycle without bus_ack; on reaching TIMEOUT, bus_req SHALL drop, the error flag SHALL be set, and the FSM SHALL go to RESP.
REQ-024 bus_ack in the same cycle the timeout is reached SHALL win (normal completion).
REQ-025 In RESP, lsu_done SHALL be 1 for exactly one cycle, lsu_err SHALL equal the error flag, and the next state SHALL be IDLE.
REQ-026 Minimum latency: accepted at edge N, bus_req high in cycle N+1, done in cycle N+2 with immediate ack.
REQ-027 lsu_valid SHALL be ignored outside IDLE; bus_ack SHALL be ignored outside REQ.
REQ-028 rdata SHALL hold its value until the next successful load; stores and errors SHALL leave it unchanged.

Reset
REQ-029 Asserting rst_n low SHALL immediately force IDLE, clear the counter and error flag, and drive rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, lsu_done=0 and lsu_err=0, even mid-transaction.

Structure
REQ-030 Package lsu_pkg SHALL hold the state enum and the funct3 size/sign constants.
REQ-031 Lane select and extension SHALL live in the combinational sub-module lsu_load_align.

Verification
REQ-032 LB at addr 0x103 with bus_rdata 0x80AABBCC and immediate ack -> rdata 0xFFFFFF80, done at cycle N+2, err 0.
REQ-033 SH at addr 0x202 with wdata 0x0000BEEF -> bus_addr 0x200, wstrb 1100, bus_wdata 0xBEEFBEEF.
REQ-034 LW at addr 0x101 -> no bus_req, done=1 and err=1 one cycle later, rdata unchanged.
REQ-035 LHU at 0x10 with ack withheld and TIMEOUT=4 -> bus_req for 4 cycles, then done with err=1.
REQ-036 rst_n low during REQ -> bus_req falls without waiting for a clock edge; after release, a new LW completes normally.
